// File: rtl/pt2262_tx_sequencer_if.sv
// Bus bundle between the PT2262 frame sequencer and its user.
//   osc       : oscillator square wave (rising edge = one osc tick)
//   te        : transmit enable, level-sensitive
//   code      : 12 trits, 2 bits each, trit 0 in code[1:0]
//   dout      : serial PT2262 waveform
//   busy      : high from word start until the final word ends
//   word_done : one-clk pulse at the end of each word's sync bit
// master drives osc/te/code, slave (the sequencer) drives the rest.
interface pt2262_tx_sequencer_if;
  logic        osc;
  logic        te;
  logic [23:0] code;
  logic        dout;
  logic        busy;
  logic        word_done;

  modport master (output osc, te, code, input dout, busy, word_done);
  modport slave  (input osc, te, code, output dout, busy, word_done);
endinterface

// File: rtl/pt2262_tx_sequencer.sv
// PT2262-compatible frame sequencer. Each rising edge of bus.osc is one
// phase step. A word is 12 trits of 32 ticks followed by a 128-tick sync
// bit (512 ticks). Words repeat back to back while te is high, and at least
// MIN_WORDS words go out per activation.
// Ports:
//   clk  : system clock
//   reset: asynchronous, active-high
//   bus  : slave side of pt2262_tx_sequencer_if (osc, te, code in;
//          dout, busy, word_done out)
module pt2262_tx_sequencer #(
  parameter int MIN_WORDS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  pt2262_tx_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_BIT, S_SYNC} state_t;

  localparam logic [3:0] MW = 4'(MIN_WORDS);

  state_t      state, state_n;
  logic [6:0]  p, p_n;
  logic [3:0]  idx, idx_n;
  logic [3:0]  wc, wc_n, wc_inc;
  logic [23:0] code_r, code_n;
  logic        osc_q, tick;
  logic        dout_r, dout_n;
  logic        wd_r, wd_n;
  logic        busy_c;
  logic [1:0]  trit_n;
  logic        long_n;

  assign tick   = bus.osc & ~osc_q;
  // Word count saturates so a long te hold cannot wrap it.
  assign wc_inc = (wc == MW) ? wc : wc + 4'd1;

  // State register plus registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      p      <= '0;
      idx    <= '0;
      wc     <= '0;
      code_r <= '0;
      osc_q  <= 1'b0;
      dout_r <= 1'b0;
      wd_r   <= 1'b0;
    end else begin
      osc_q  <= bus.osc;
      state  <= state_n;
      p      <= p_n;
      idx    <= idx_n;
      wc     <= wc_n;
      code_r <= code_n;
      wd_r   <= wd_n;
      // dout only moves on ticks, so it is flat between osc edges.
      if (tick) dout_r <= dout_n;
    end
  end

  // Next-state logic: everything holds unless this clk carries a tick.
  always_comb begin
    state_n = state;
    p_n     = p;
    idx_n   = idx;
    wc_n    = wc;
    code_n  = code_r;
    if (tick) begin
      unique case (state)
        S_IDLE: begin
          if (bus.te) begin
            state_n = S_BIT;
            code_n  = bus.code;
            p_n     = '0;
            idx_n   = '0;
            wc_n    = '0;
          end
        end
        S_BIT: begin
          if (p == 7'd31) begin
            p_n = '0;
            if (idx == 4'd11) begin
              state_n = S_SYNC;
              idx_n   = '0;
            end else begin
              idx_n = idx + 4'd1;
            end
          end else begin
            p_n = p + 7'd1;
          end
        end
        S_SYNC: begin
          if (p == 7'd127) begin
            p_n   = '0;
            idx_n = '0;
            wc_n  = wc_inc;
            if (bus.te || (wc_inc < MW)) begin
              state_n = S_BIT;
              code_n  = bus.code;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            p_n = p + 7'd1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Output logic. The waveform is evaluated on the *next* state so the
  // registered dout already shows the new phase on the tick edge.
  always_comb begin
    trit_n = 2'(code_n >> {idx_n, 1'b0});
    // '1' is long/long; 'F' (01 or 10) is short then long.
    long_n = (trit_n == 2'b11) | (p_n[4] & (trit_n[0] ^ trit_n[1]));
    dout_n = 1'b0;
    unique case (state_n)
      S_BIT:   dout_n = long_n ? (p_n[3:0] < 4'd12) : (p_n[3:0] < 4'd4);
      S_SYNC:  dout_n = (p_n < 7'd4);
      default: dout_n = 1'b0;
    endcase
    wd_n   = tick & (state == S_SYNC) & (p == 7'd127);
    busy_c = (state != S_IDLE);
  end

  assign bus.dout      = dout_r;
  assign bus.busy      = busy_c;
  assign bus.word_done = wd_r;

endmodule

// File: tb/tb_pt2262_tx_sequencer.sv
// Directed bench for pt2262_tx_sequencer. Two instances: ia with
// MIN_WORDS=4 and ib with MIN_WORDS=1. osc runs at 4 clks per period.
module tb_pt2262_tx_sequencer;
  logic clk = 1'b0;
  logic reset;
  logic osc;
  int   checks = 0;
  int   errors = 0;
  logic [511:0] last_w;

  pt2262_tx_sequencer_if ia ();
  pt2262_tx_sequencer_if ib ();

  pt2262_tx_sequencer #(.MIN_WORDS(4)) u_a (.clk(clk), .reset(reset), .bus(ia));
  pt2262_tx_sequencer #(.MIN_WORDS(1)) u_b (.clk(clk), .reset(reset), .bus(ib));

  always #5 clk = ~clk;

  initial begin
    osc = 1'b0; ia.osc = 1'b0; ib.osc = 1'b0;
    forever begin
      repeat (2) @(posedge clk);
      #1;
      osc = ~osc; ia.osc = osc; ib.osc = osc;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    int first = 0;
    for (int i = 511; i >= 0; i--) if (obs[i] !== exp[i]) first = i;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed dout %b expected %b at word tick %0d", tag, obs[first], exp[first], first);
    end
  endtask

  // Expected word as pulse runs: short half = 4 high/12 low,
  // long half = 12 high/4 low, sync = 4 high/124 low.
  function automatic logic [511:0] exp_word(input logic [23:0] c);
    logic [511:0] w = '0;
    int k = 0;
    int hi;
    logic [1:0] tr;
    for (int t = 0; t < 12; t++) begin
      tr = c[2*t +: 2];
      for (int h = 0; h < 2; h++) begin
        if (tr == 2'b11) hi = 12;
        else if (tr == 2'b00) hi = 4;
        else hi = (h == 1) ? 12 : 4;
        for (int j = 0; j < 16; j++) begin w[k] = (j < hi); k++; end
      end
    end
    for (int j = 0; j < 128; j++) begin w[k] = (j < 4); k++; end
    return w;
  endfunction

  // Return 2 time units after the clk edge on which the DUT sees a tick.
  task automatic next_tick();
    @(posedge osc);
    @(posedge clk);
    #2;
  endtask

  task automatic set_code(input logic [23:0] c);
    ia.code = c; ib.code = c;
  endtask

  task automatic set_te(input bit sel, input logic v);
    if (sel) ib.te = v; else ia.te = v;
  endtask

  // Start a burst: te covers exactly one tick unless hold is set.
  task automatic start(input bit sel, input bit hold);
    set_te(sel, 1'b1);
    next_tick();
    if (!hold) set_te(sel, 1'b0);
  endtask

  // Called right after a word's first tick; returns right after the tick
  // that ends the word. Optionally changes code/te at word tick act_at.
  task automatic capture(input bit sel, input logic [23:0] ecode, input int act_at,
                         input logic [23:0] ncode, input logic nte, input string tag);
    logic [511:0] w;
    int busy_low = 0;
    int wd_bad = 0;
    for (int k = 0; k < 512; k++) begin
      w[k] = sel ? ib.dout : ia.dout;
      if (!(sel ? ib.busy : ia.busy)) busy_low++;
      if (k > 0 && (sel ? ib.word_done : ia.word_done)) wd_bad++;
      if (k == act_at) begin set_code(ncode); set_te(sel, nte); end
      next_tick();
    end
    last_w = w;
    chkw({tag, ".wave"}, w, exp_word(ecode));
    chk({tag, ".busy_in_word"}, busy_low, 0);
    chk({tag, ".wd_mid"}, wd_bad, 0);
    chk({tag, ".wd_end"}, sel ? ib.word_done : ia.word_done, 1);
  endtask

  initial begin
    reset = 1'b1;
    ia.te = 1'b0; ib.te = 1'b0;
    set_code(24'h0);
    #33;
    chk("rst.dout", ia.dout, 0);
    chk("rst.busy", ia.busy, 0);
    chk("rst.wd", ia.word_done, 0);
    chk("rst.busy_b", ib.busy, 0);
    @(negedge osc); #1 reset = 1'b0;
    repeat (2) next_tick();

    // Single word of '0' trits, MIN_WORDS=1.
    start(1, 0);
    capture(1, 24'h0, -1, 24'h0, 1'b0, "w0");
    chk("w0.ones", $countones(last_w), 100);
    chk("w0.t16", last_w[16], 1);
    chk("w0.t20", last_w[20], 0);
    chk("w0.busy_end", ib.busy, 0);
    chk("w0.dout_end", ib.dout, 0);
    @(posedge clk); #2;
    chk("w0.wd_one_clk", ib.word_done, 0);
    next_tick();
    chk("w0.stay_idle", ib.busy, 0);

    // te pulse that covers no tick is ignored.
    ib.te = 1'b1;
    @(posedge clk); #2;
    ib.te = 1'b0;
    next_tick();
    chk("notick.busy", ib.busy, 0);

    // Encoding: trit0='1', trit1='F'(01), trit2='F'(10).
    set_code(24'h000027);
    start(1, 0);
    capture(1, 24'h000027, -1, 24'h0, 1'b0, "enc");
    chk("enc.t11", last_w[11], 1);
    chk("enc.t12", last_w[12], 0);
    chk("enc.t28", last_w[28], 0);
    chk("enc.t36", last_w[36], 0);
    chk("enc.t59", last_w[59], 1);
    chk("enc.t68", last_w[68], 0);
    chk("enc.t91", last_w[91], 1);
    chk("enc.t116", last_w[116], 0);
    chk("enc.t387", last_w[387], 1);
    chk("enc.t388", last_w[388], 0);

    // Minimum burst of 4 with a code change at tick 100 of word 1.
    set_code(24'hA5C396);
    start(0, 0);
    capture(0, 24'hA5C396, 100, 24'h3C0F5A, 1'b0, "mb1");
    capture(0, 24'h3C0F5A, -1, 24'h3C0F5A, 1'b0, "mb2");
    capture(0, 24'h3C0F5A, -1, 24'h3C0F5A, 1'b0, "mb3");
    chk("mb3.busy_gapless", ia.busy, 1);
    capture(0, 24'h3C0F5A, -1, 24'h3C0F5A, 1'b0, "mb4");
    chk("mb4.busy_end", ia.busy, 0);
    next_tick();
    chk("mb.no_fifth", ia.busy, 0);

    // Held enable for ~2800 ticks gives 6 words.
    set_code(24'h00FF33);
    start(0, 1);
    for (int n = 1; n <= 5; n++) begin
      capture(0, 24'h00FF33, -1, 24'h00FF33, 1'b1, $sformatf("he%0d", n));
      chk($sformatf("he%0d.busy", n), ia.busy, 1);
    end
    capture(0, 24'h00FF33, 240, 24'h00FF33, 1'b0, "he6");
    chk("he6.busy_end", ia.busy, 0);
    next_tick();
    chk("he.no_seventh", ia.busy, 0);

    // Reset mid-word, then a fresh start.
    set_code(24'hFFFFFF);
    start(0, 0);
    repeat (200) next_tick();
    chk("rmw.pre_dout", ia.dout, 1);
    #1 reset = 1'b1;
    #1;
    chk("rmw.dout", ia.dout, 0);
    chk("rmw.busy", ia.busy, 0);
    chk("rmw.wd", ia.word_done, 0);
    set_code(24'h000003);
    ia.te = 1'b1;
    repeat (2) next_tick();
    chk("rmw.held", ia.busy, 0);
    @(negedge osc); #1 reset = 1'b0;
    next_tick();
    ia.te = 1'b0;
    capture(0, 24'h000003, -1, 24'h000003, 1'b0, "rmw.fresh");
    chk("rmw.burst_continues", ia.busy, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pt2262_tx_sequencer.md
# pt2262_tx_sequencer

Frame sequencer for the PT2262-compatible encoder. It consumes the oscillator square wave from the 12 kHz-class clock divider and uses each rising edge as one oscillator period ("osc tick"). It serialises a 12-trit code word plus sync bit onto a single output line, in PT2262 pulse format. While transmit-enable is asserted it repeats words back to back, and it always sends at least `MIN_WORDS` complete words per activation.

## Interface
- `MIN_WORDS`, default 4: minimum number of complete words sent per activation, in the range 1..15.
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `osc`  in  1: oscillator square wave from the divider, synchronous to `clk`. Each rising edge is one osc tick.
- `te`  in  1: transmit enable, level-sensitive.
- `code`  in  24: 12 trits, 2 bits each. Trit i is `code[2i+1:2i]`; trit 0 is sent first. Encoding: 00 = '0', 11 = '1', 01 = 'F', 10 = 'F' (reserved).
- `dout`  out  1: serial PT2262 waveform.
- `busy`  out  1: high from word start until the final word ends.
- `word_done`  out  1: one-clk pulse at the end of each word's sync bit.

## Operation
- Tick detection:
  - `osc_q` registers `osc`.
  - `tick = osc & ~osc_q`.
  - All state changes occur only on clk edges where `tick` = 1.
- States:
  - IDLE: `dout` = 0, `busy` = 0.
  - BIT: phase counter `p` runs 0..31; trit index `idx` runs 0..11.
  - SYNC: `p` runs 0..127.
- Trit waveform (`p` in 0..31, h = `p[4]`, q = `p[3:0]`):
  - A short half is high for q < 4, low otherwise.
  - A long half is high for q < 12, low otherwise.
  - '0' = short, short.
  - '1' = long, long.
  - 'F' = short (h=0), then long (h=1).
- Sync waveform: high for `p` < 4, low for `p` 4..127.
- Word length: 12 × 32 + 128 = 512 osc ticks.
- IDLE → BIT: on a tick with `te` = 1.
  - Latch `code` into `code_r`.
  - `p`, `idx`, `word_cnt` ← 0.
  - `busy` ← 1.
  - `dout` ← 1, since every symbol starts high.
- BIT:
  - Each tick increments `p`.
  - At `p` = 31, clear `p` and increment `idx`.
  - At `idx` = 11 and `p` = 31, go to SYNC with `p` ← 0.
- SYNC end (tick at `p` = 127):
  - `word_done` ← 1 for one clk.
  - `word_cnt` increments, saturating at `MIN_WORDS`.
  - If `te` = 1 or the incremented count < `MIN_WORDS`: go to BIT, re-latch `code`, `p` = `idx` = 0, `dout` ← 1.
  - Otherwise: go to IDLE, `dout` ← 0, `busy` ← 0.
- `dout` is registered. On each tick it takes the waveform value of the new (`state`, `p`, `idx`). It is glitch-free and constant between ticks.
- `code` is sampled only at word start. Changes mid-word do not affect the word in flight.
- `te` deasserting mid-word never truncates the word.
- A `te` pulse shorter than one osc period that covers a tick still starts a full `MIN_WORDS` burst. A pulse that covers no tick is ignored.
- Reset (asynchronous, any time, including mid-word):
  - State IDLE, all counters 0, `code_r` = 0, `osc_q` = 0.
  - `dout` = 0, `busy` = 0, `word_done` = 0.
  - The partial word is abandoned. If `osc` is high when reset is released, the next clk sees a spurious tick (`osc_q` = 0); a start on that tick is legal.

## Timing
- Start latency: `dout`/`busy` rise on the clk edge of the first tick where `te` = 1. That is 1 clk after the osc rising edge is visible at the input.
- Each osc period is exactly one phase step.
- The first word ends 512 ticks after start: `word_done` is asserted for the single clk following that tick.
- Back-to-back words have no gap. The next word's first high phase immediately follows the sync low of 124 ticks.
- Burst length in words is max(`MIN_WORDS`, number of word boundaries at which `te` = 1, plus 1).
- Counter widths: `p` 7 bits, `idx` 4 bits, `word_cnt` 4 bits.

## Test plan
- **Single word of '0' trits:** `code` = 0, `te` pulsed for one tick, `MIN_WORDS` = 1.
  - `dout` repeats high 4 / low 12 ticks for 24 half-bits.
  - Then high 4 / low 124.
  - `word_done` pulses once at tick 512; `busy` falls in the same clk.
- **Encoding:** trit 0 = 11, trit 1 = 01, trit 2 = 10, rest 00.
  - Bit 0: high 12 / low 4, twice.
  - Bits 1 and 2: high 4 / low 12, then high 12 / low 4.
  - Remaining bits: short/short.
- **Minimum burst:** `te` high for one tick, `MIN_WORDS` = 4 → exactly 4 `word_done` pulses, no inter-word gap, `busy` high for 2048 ticks.
- **Held enable:** `te` high for 2800 ticks → 6 words. `te` is still high at the 5th boundary (tick 2560) and falls mid-word 6; word 6 completes.
- **Code stability:** change `code` at tick 100 of word 1 → word 1 is unaffected; word 2 carries the new code.
- **Reset mid-word:** assert `reset` at tick 200 → `dout`, `busy`, and `word_done` are 0 immediately. After release with `te` = 1, a fresh word starts at trit 0, `p` = 0.
